// File: rtl/alu_issue_queue.sv
// Collapsing, age-ordered ALU issue queue with PRF write-back wakeup snooping.
// Optional performance counters are compiled in with ALU_IQ_PERF_EN.

package alu_iq_pkg;
    localparam int IQ_PRF_AW = 6;

    typedef struct packed {
        logic                 valid;
        logic [3:0]           aluop;
        logic [IQ_PRF_AW-1:0] op0PAddr;
        logic [IQ_PRF_AW-1:0] op1PAddr;
        logic                 op0re;
        logic                 op1re;
        logic [IQ_PRF_AW-1:0] dstPAddr;
        logic                 dstwe;
        logic [31:0]          imm;
        logic [7:0]           tag;
    } UOPBundle;

    typedef struct packed {
        logic                 wen;
        logic [IQ_PRF_AW-1:0] rd;
        logic [31:0]          data;
    } PRFwInfo;
endpackage

module alu_issue_queue
    import alu_iq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int PRF_AW = IQ_PRF_AW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  UOPBundle                 enq_uop,
    input  logic                     enq_src0_rdy,
    input  logic                     enq_src1_rdy,
    input  PRFwInfo                  wk0,
    input  PRFwInfo                  wk1,
    output logic                     iss_valid,
    input  logic                     iss_ready,
    output UOPBundle                 iss_uop,
    output logic [$clog2(DEPTH):0]   count
`ifdef ALU_IQ_PERF_EN
    ,
    output logic [31:0]              perf_full_cycles,
    output logic [31:0]              perf_stall_cycles
`endif
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0] FULL_CNT = (IW+1)'(DEPTH);

    function automatic logic wake_hit(input PRFwInfo a, input PRFwInfo b,
                                      input logic [PRF_AW-1:0] paddr);
        return (a.wen && (a.rd == paddr)) || (b.wen && (b.rd == paddr));
    endfunction

    logic [IW:0]      count_reg, count_next;
    logic [DEPTH-1:0] v_reg, r0_reg, r1_reg;
    logic [DEPTH-1:0] v_next, r0_next, r1_next;
    UOPBundle         uop_reg  [DEPTH];
    UOPBundle         uop_next [DEPTH];
    logic             iss_valid_reg;
    UOPBundle         iss_uop_reg;

    logic [DEPTH-1:0] m0, m1, cand;
    // Wakeup-applied view of the entries plus an always-empty sentinel at DEPTH
    // so the top entry can shift in "nothing" during compaction.
    logic [DEPTH:0]   cur_v, cur_r0, cur_r1;
    UOPBundle         cur_uop [DEPTH+1];

    logic             has_cand;
    logic [IW-1:0]    sel_idx;
    logic             slot_load, deq, enq_fire;
    logic             enq_r0, enq_r1;
    logic [IW:0]      wr_idx;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign m0[gi]      = wake_hit(wk0, wk1, uop_reg[gi].op0PAddr);
            assign m1[gi]      = wake_hit(wk0, wk1, uop_reg[gi].op1PAddr);
            assign cand[gi]    = v_reg[gi] & r0_reg[gi] & r1_reg[gi];
            assign cur_v[gi]   = v_reg[gi];
            assign cur_r0[gi]  = r0_reg[gi] | (v_reg[gi] & m0[gi]);
            assign cur_r1[gi]  = r1_reg[gi] | (v_reg[gi] & m1[gi]);
            assign cur_uop[gi] = uop_reg[gi];
        end
    endgenerate

    assign cur_v[DEPTH]   = 1'b0;
    assign cur_r0[DEPTH]  = 1'b0;
    assign cur_r1[DEPTH]  = 1'b0;
    assign cur_uop[DEPTH] = '0;

    // Oldest-first select on registered readiness; this cycle's wakeups count next cycle.
    always_comb begin
        has_cand = 1'b0;
        sel_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                has_cand = 1'b1;
                sel_idx  = IW'(i);
            end
        end
    end

    assign slot_load = !iss_valid_reg || iss_ready;
    assign deq       = slot_load && has_cand;
    assign enq_ready = (count_reg != FULL_CNT);
    assign enq_fire  = enq_valid && enq_ready && !flush;
    assign enq_r0    = enq_src0_rdy | ~enq_uop.op0re | wake_hit(wk0, wk1, enq_uop.op0PAddr);
    assign enq_r1    = enq_src1_rdy | ~enq_uop.op1re | wake_hit(wk0, wk1, enq_uop.op1PAddr);
    assign wr_idx    = count_reg - (IW+1)'(deq);
    assign count_next = count_reg + (IW+1)'(enq_fire) - (IW+1)'(deq);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            int src;
            src = (deq && (IW'(i) >= sel_idx)) ? i + 1 : i;
            v_next[i]   = cur_v[src];
            r0_next[i]  = cur_r0[src];
            r1_next[i]  = cur_r1[src];
            uop_next[i] = cur_uop[src];
            if (enq_fire && (wr_idx == (IW+1)'(i))) begin
                v_next[i]   = 1'b1;
                r0_next[i]  = enq_r0;
                r1_next[i]  = enq_r1;
                uop_next[i] = enq_uop;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v_reg         <= '0;
            r0_reg        <= '0;
            r1_reg        <= '0;
            count_reg     <= '0;
            iss_valid_reg <= 1'b0;
            iss_uop_reg   <= '0;
        end else if (flush) begin
            v_reg         <= '0;
            r0_reg        <= '0;
            r1_reg        <= '0;
            count_reg     <= '0;
            iss_valid_reg <= 1'b0;
        end else begin
            v_reg     <= v_next;
            r0_reg    <= r0_next;
            r1_reg    <= r1_next;
            count_reg <= count_next;
            if (slot_load) begin
                iss_valid_reg <= has_cand;
                if (has_cand) begin
                    iss_uop_reg <= uop_reg[sel_idx];
                end
            end
        end
    end

    // Payload needs no reset: it is only observed through valid entries.
    always_ff @(posedge clk) begin
        uop_reg <= uop_next;
    end

    always_comb begin
        iss_uop       = iss_uop_reg;
        iss_uop.valid = iss_valid_reg;
    end

    assign iss_valid = iss_valid_reg;
    assign count     = count_reg;

    logic unused_bits;
    assign unused_bits = ^{wk0.data, wk1.data, iss_uop_reg.valid};

`ifdef ALU_IQ_PERF_EN
    logic [31:0] perf_full_reg, perf_stall_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_full_reg  <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (count_reg == FULL_CNT) begin
                perf_full_reg <= perf_full_reg + 32'd1;
            end
            if (iss_valid_reg && !iss_ready) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_full_cycles  = perf_full_reg;
    assign perf_stall_cycles = perf_stall_reg;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed + random bench for alu_issue_queue against a queue-based reference model.
module tb_alu_issue_queue;
    import alu_iq_pkg::*;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst, flush, enq_valid, enq_ready, enq_src0_rdy, enq_src1_rdy;
    logic       iss_valid, iss_ready;
    UOPBundle   enq_uop, iss_uop;
    PRFwInfo    wk0, wk1;
    logic [$clog2(DEPTH):0] count;
`ifdef ALU_IQ_PERF_EN
    logic [31:0] perf_full_cycles, perf_stall_cycles;
    logic [31:0] m_full, m_stall;
`endif

    always #5 clk = ~clk;

    alu_issue_queue #(.DEPTH(DEPTH), .PRF_AW(IQ_PRF_AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_uop(enq_uop),
        .enq_src0_rdy(enq_src0_rdy), .enq_src1_rdy(enq_src1_rdy),
        .wk0(wk0), .wk1(wk1),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_uop(iss_uop),
        .count(count)
`ifdef ALU_IQ_PERF_EN
        , .perf_full_cycles(perf_full_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    typedef struct {
        UOPBundle u;
        bit       r0;
        bit       r1;
    } ent_t;

    ent_t        mq[$];
    bit          m_iss_v;
    UOPBundle    m_iss_u;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic UOPBundle mk(input logic [7:0] tag, input logic [IQ_PRF_AW-1:0] a0,
                                    input logic re0, input logic [IQ_PRF_AW-1:0] a1,
                                    input logic re1);
        UOPBundle u;
        u          = '0;
        u.valid    = 1'b1;
        u.aluop    = tag[3:0];
        u.op0PAddr = a0;
        u.op1PAddr = a1;
        u.op0re    = re0;
        u.op1re    = re1;
        u.dstPAddr = tag[5:0];
        u.dstwe    = 1'b1;
        u.imm      = {4{tag}};
        u.tag      = tag;
        return u;
    endfunction

    function automatic bit hit(input logic [IQ_PRF_AW-1:0] p);
        return (wk0.wen && wk0.rd == p) || (wk1.wen && wk1.rd == p);
    endfunction

    // Reference: oldest ready uop (by position in an age-ordered queue) moves to the slot.
    task automatic model_step();
        int   idx;
        bit   can_load, do_enq;
        ent_t e;
`ifdef ALU_IQ_PERF_EN
        if (rst) begin
            if (mq.size() == DEPTH) m_full++;
            if (m_iss_v && !iss_ready) m_stall++;
        end
`endif
        if (!rst) begin
            mq.delete();
            m_iss_v = 0;
            m_iss_u = '0;
`ifdef ALU_IQ_PERF_EN
            m_full  = 0;
            m_stall = 0;
`endif
            return;
        end
        if (flush) begin
            mq.delete();
            m_iss_v = 0;
            return;
        end
        idx = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].r0 && mq[i].r1) begin
                idx = i;
                break;
            end
        end
        can_load = !m_iss_v || iss_ready;
        do_enq   = enq_valid && (mq.size() != DEPTH);
        foreach (mq[i]) begin
            if (hit(mq[i].u.op0PAddr)) mq[i].r0 = 1;
            if (hit(mq[i].u.op1PAddr)) mq[i].r1 = 1;
        end
        if (can_load) begin
            if (idx >= 0) begin
                m_iss_u = mq[idx].u;
                m_iss_v = 1;
                mq.delete(idx);
                $display("issue tag=%02h queued=%0d", m_iss_u.tag, mq.size());
            end else begin
                m_iss_v = 0;
            end
        end
        if (do_enq) begin
            e.u  = enq_uop;
            e.r0 = enq_src0_rdy || !enq_uop.op0re || hit(enq_uop.op0PAddr);
            e.r1 = enq_src1_rdy || !enq_uop.op1re || hit(enq_uop.op1PAddr);
            mq.push_back(e);
        end
    endtask

    task automatic check_all();
        UOPBundle exp_u;
        chk("count", 128'(count), 128'(mq.size()));
        chk("enq_ready", 128'(enq_ready), 128'(mq.size() != DEPTH));
        chk("iss_valid", 128'(iss_valid), 128'(m_iss_v));
        if (m_iss_v) begin
            exp_u       = m_iss_u;
            exp_u.valid = 1'b1;
            chk("iss_uop", 128'(iss_uop), 128'(exp_u));
        end else begin
            chk("iss_uop.valid", 128'(iss_uop.valid), 128'(0));
        end
`ifdef ALU_IQ_PERF_EN
        chk("perf_full", 128'(perf_full_cycles), 128'(m_full));
        chk("perf_stall", 128'(perf_stall_cycles), 128'(m_stall));
`endif
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        flush        = 0;
        enq_valid    = 0;
        enq_uop      = '0;
        enq_src0_rdy = 0;
        enq_src1_rdy = 0;
        wk0          = '0;
        wk1          = '0;
    endtask

    initial begin
        idle();
        rst       = 0;
        iss_ready = 1;
        m_iss_v   = 0;
        m_iss_u   = '0;
`ifdef ALU_IQ_PERF_EN
        m_full  = 0;
        m_stall = 0;
`endif
        @(negedge clk);
        cyc();
        cyc();
        chk("rst_iss_uop", 128'(iss_uop), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        rst = 1;
        cyc();
        chk("rst_enq_ready", 128'(enq_ready), 128'(1));

        // A: src0 ready via busy table, src1 unused -> issues one edge after enqueue
        enq_valid = 1; enq_uop = mk(8'hA1, 6'd3, 1'b1, 6'd0, 1'b0); enq_src0_rdy = 1;
        cyc();
        idle();
        cyc();
        chk("A_valid", 128'(iss_valid), 128'(1));
        chk("A_tag", 128'(iss_uop.tag), 128'(8'hA1));
        chk("A_count", 128'(count), 128'(0));

        // B waits on P5, C is ready: C overtakes B
        enq_valid = 1; enq_uop = mk(8'hB2, 6'd5, 1'b1, 6'd0, 1'b0);
        cyc();
        enq_valid = 1; enq_uop = mk(8'hC3, 6'd1, 1'b1, 6'd2, 1'b1);
        enq_src0_rdy = 1; enq_src1_rdy = 1;
        cyc();
        idle();
        cyc();
        chk("C_first", 128'(iss_uop.tag), 128'(8'hC3));
        wk1.wen = 1; wk1.rd = 6'd5;
        cyc();
        idle();
        chk("B_not_yet", 128'(iss_valid), 128'(0));
        cyc();
        chk("B_tag", 128'(iss_uop.tag), 128'(8'hB2));

        // D: wakeup for P9 arrives in the enqueue cycle
        enq_valid = 1; enq_uop = mk(8'hD4, 6'd0, 1'b0, 6'd9, 1'b1);
        wk0.wen = 1; wk0.rd = 6'd9;
        cyc();
        idle();
        cyc();
        chk("D_tag", 128'(iss_uop.tag), 128'(8'hD4));

        // Fill with uops waiting on P20..P27
        for (int i = 0; i < DEPTH; i++) begin
            enq_valid = 1;
            enq_uop   = mk(8'(8'h10 + i), 6'(20 + i), 1'b1, 6'd0, 1'b0);
            cyc();
        end
        idle();
        chk("full_count", 128'(count), 128'(DEPTH));
        chk("full_enq_ready", 128'(enq_ready), 128'(0));
        wk0.wen = 1; wk0.rd = 6'd23;
        cyc();
        idle();
        cyc();
        chk("mid_tag", 128'(iss_uop.tag), 128'(8'h13));
        chk("mid_count", 128'(count), 128'(DEPTH - 1));
        chk("mid_enq_ready", 128'(enq_ready), 128'(1));
        wk0.wen = 1; wk0.rd = 6'd20; wk1.wen = 1; wk1.rd = 6'd27;
        cyc();
        idle();
        cyc();
        chk("age_tag", 128'(iss_uop.tag), 128'(8'h10));

        // Stall the slot for three cycles
        iss_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_tag", 128'(iss_uop.tag), 128'(8'h10));
            chk("stall_count", 128'(count), 128'(6));
        end
`ifdef ALU_IQ_PERF_EN
        chk("stall_perf", 128'(perf_stall_cycles), 128'(3));
`endif
        iss_ready = 1;
        cyc();
        chk("after_stall_tag", 128'(iss_uop.tag), 128'(8'h17));
        chk("pre_flush_count", 128'(count), 128'(5));

        // Flush with a concurrent enqueue
        flush = 1; enq_valid = 1; enq_uop = mk(8'hEE, 6'd1, 1'b0, 6'd1, 1'b0);
        cyc();
        idle();
        chk("flush_count", 128'(count), 128'(0));
        chk("flush_iss_valid", 128'(iss_valid), 128'(0));
        cyc();
        chk("flush_drop", 128'(count), 128'(0));

        // Random traffic, including occasional flush and reset
        for (int n = 0; n < 800; n++) begin
            rst          = ($urandom_range(0, 99) != 0);
            flush        = ($urandom_range(0, 49) == 0);
            enq_valid    = ($urandom_range(0, 99) < 60);
            enq_uop      = mk(8'($urandom), 6'($urandom_range(0, 7)), 1'($urandom),
                              6'($urandom_range(0, 7)), 1'($urandom));
            enq_src0_rdy = ($urandom_range(0, 3) == 0);
            enq_src1_rdy = ($urandom_range(0, 3) == 0);
            wk0.wen      = ($urandom_range(0, 2) == 0);
            wk0.rd       = 6'($urandom_range(0, 7));
            wk0.data     = $urandom;
            wk1.wen      = ($urandom_range(0, 2) == 0);
            wk1.rd       = 6'($urandom_range(0, 7));
            wk1.data     = $urandom;
            iss_ready    = ($urandom_range(0, 99) < 70);
            cyc();
            if (!rst) chk("rnd_rst_iss_uop", 128'(iss_uop), 128'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
